// File: rtl/lrwait_tcdm_queue.sv
`default_nettype none
// ============================================================================
// Module   : lrwait_tcdm_queue
// Purpose  : Bank-side LRWait/SCWait reservation queues in front of one TCDM
//            SRAM bank. The first LRWait to an address is answered from
//            memory. Later LRWaits become SuccUpdates to the previous tail.
//            WakeUps hand the reservation to the next head.
// Revision : 1.0 - initial release
// ============================================================================
module lrwait_tcdm_queue #(
  parameter int unsigned NumQueues    = 2,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned MetaWidth    = 16,
  parameter int unsigned MemAddrWidth = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [AddrWidth-1:0]    in_addr_i,
  input  logic                    in_write_i,
  input  logic [3:0]              in_amo_i,
  input  logic [DataWidth-1:0]    in_wdata_i,
  input  logic [DataWidth/8-1:0]  in_be_i,
  input  logic [MetaWidth-1:0]    in_meta_i,
  input  logic                    in_lrwait_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [DataWidth-1:0]    out_rdata_o,
  output logic [MetaWidth-1:0]    out_meta_o,
  output logic                    out_lrwait_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [MemAddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  output logic [DataWidth/8-1:0]  mem_be_o,
  input  logic [DataWidth-1:0]    mem_rdata_i
);

  localparam int unsigned c_idx_w       = (NumQueues > 1) ? $clog2(NumQueues) : 1;
  localparam logic [3:0]  c_amo_lrwait  = 4'hC;
  localparam logic [3:0]  c_amo_scwait  = 4'hD;

  // Reservation queue state
  logic [NumQueues-1:0] r_q_valid;
  logic [AddrWidth-1:0] r_q_addr [NumQueues];
  logic [MetaWidth-1:0] r_q_head [NumQueues];
  logic [MetaWidth-1:0] r_q_tail [NumQueues];

  // Response register
  logic                 r_out_valid;
  logic                 r_out_lrwait;
  logic                 r_out_fresh;
  logic [MetaWidth-1:0] r_out_meta;
  logic [DataWidth-1:0] r_out_rdata;

  logic                 w_hit;
  logic [c_idx_w-1:0]   w_hit_idx;
  logic                 w_free;
  logic [c_idx_w-1:0]   w_free_idx;
  logic                 w_wakeup;
  logic                 w_lr;
  logic                 w_sc;
  logic                 w_sc_ok;
  logic                 w_stall;
  logic                 w_accept;
  logic                 w_resp;
  logic                 w_resp_read;
  logic                 w_resp_lrwait;
  logic [MetaWidth-1:0] w_resp_meta;
  logic [DataWidth-1:0] w_resp_data;

  // Lowest-index matching queue and lowest-index free queue (descending scan)
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = NumQueues - 1; i >= 0; i--) begin
      if (r_q_valid[i] && (r_q_addr[i] == in_addr_i)) begin
        w_hit     = 1'b1;
        w_hit_idx = c_idx_w'(i);
      end
      if (!r_q_valid[i]) begin
        w_free     = 1'b1;
        w_free_idx = c_idx_w'(i);
      end
    end
  end

  assign w_wakeup   = (in_amo_i == c_amo_lrwait) && in_lrwait_i;
  assign w_lr       = (in_amo_i == c_amo_lrwait) && !in_lrwait_i;
  assign w_sc       = (in_amo_i == c_amo_scwait);
  assign w_sc_ok    = w_sc && w_hit && (in_meta_i == r_q_head[w_hit_idx]);
  // A new reservation with every queue taken must wait for one to free up
  assign w_stall    = w_lr && !w_hit && !w_free;
  assign in_ready_o = !rst_i && (!r_out_valid || out_ready_i) && !w_stall;
  assign w_accept   = in_valid_i && in_ready_o;

  // Request decode: SRAM access and the response to be captured
  always_comb begin
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = in_addr_i[MemAddrWidth+1:2];
    mem_wdata_o   = in_wdata_i;
    mem_be_o      = in_be_i;
    w_resp        = 1'b0;
    w_resp_read   = 1'b0;
    w_resp_lrwait = 1'b0;
    w_resp_meta   = in_meta_i;
    w_resp_data   = '0;
    if (w_accept) begin
      if (w_wakeup) begin
        // Missed WakeUps are dropped silently
        if (w_hit) begin
          mem_req_o   = 1'b1;
          w_resp      = 1'b1;
          w_resp_read = 1'b1;
          w_resp_meta = in_wdata_i[MetaWidth-1:0];
        end
      end else if (w_lr) begin
        if (w_hit) begin
          // SuccUpdate to the old tail carrying the new requester's meta
          w_resp        = 1'b1;
          w_resp_lrwait = 1'b1;
          w_resp_meta   = r_q_tail[w_hit_idx];
          w_resp_data   = DataWidth'(in_meta_i);
        end else begin
          mem_req_o   = 1'b1;
          w_resp      = 1'b1;
          w_resp_read = 1'b1;
        end
      end else if (w_sc) begin
        w_resp = 1'b1;
        if (w_sc_ok) begin
          mem_req_o = 1'b1;
          mem_we_o  = 1'b1;
        end else begin
          w_resp_data = DataWidth'(1);
        end
      end else begin
        mem_req_o   = 1'b1;
        mem_we_o    = in_write_i;
        w_resp      = 1'b1;
        w_resp_read = !in_write_i;
      end
    end
  end

  // Queue allocation, tail append, head hand-over and release
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_q_valid <= '0;
      for (int i = 0; i < NumQueues; i++) begin
        r_q_addr[i] <= '0;
        r_q_head[i] <= '0;
        r_q_tail[i] <= '0;
      end
    end else if (w_accept) begin
      if (w_wakeup && w_hit) begin
        r_q_head[w_hit_idx] <= in_wdata_i[MetaWidth-1:0];
      end
      if (w_lr && w_hit) begin
        r_q_tail[w_hit_idx] <= in_meta_i;
      end
      if (w_lr && !w_hit) begin
        r_q_valid[w_free_idx] <= 1'b1;
        r_q_addr[w_free_idx]  <= in_addr_i;
        r_q_head[w_free_idx]  <= in_meta_i;
        r_q_tail[w_free_idx]  <= in_meta_i;
      end
      if (w_sc_ok && (r_q_head[w_hit_idx] == r_q_tail[w_hit_idx])) begin
        r_q_valid[w_hit_idx] <= 1'b0;
      end
    end
  end

  // Response register; fresh read data is passed through once, then held
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_valid  <= 1'b0;
      r_out_lrwait <= 1'b0;
      r_out_fresh  <= 1'b0;
      r_out_meta   <= '0;
      r_out_rdata  <= '0;
    end else if (w_accept && w_resp) begin
      r_out_valid  <= 1'b1;
      r_out_lrwait <= w_resp_lrwait;
      r_out_fresh  <= w_resp_read;
      r_out_meta   <= w_resp_meta;
      r_out_rdata  <= w_resp_data;
    end else begin
      if (out_ready_i) begin
        r_out_valid <= 1'b0;
      end
      if (r_out_fresh) begin
        r_out_rdata <= mem_rdata_i;
        r_out_fresh <= 1'b0;
      end
    end
  end

  assign out_valid_o  = r_out_valid;
  assign out_lrwait_o = r_out_lrwait;
  assign out_meta_o   = r_out_meta;
  assign out_rdata_o  = r_out_fresh ? mem_rdata_i : r_out_rdata;

endmodule
`default_nettype wire
